// File: rtl/kyber_enc_host_seq_if.sv
// Bus bundle between the Kyber encryption host sequencer and its surroundings
// (input buffer, kyber_enc_core and output buffer).
//
// Signals (direction as seen from the sequencer, modport master):
//   start       in   single-cycle request to run one encryption
//   in_re       out  input buffer read enable
//   in_addr     out  input buffer read address (AW bits)
//   in_rdata    in   input buffer read data, valid the cycle after in_re
//   core_en     out  start pulse to core en
//   core_wen    out  to core wen
//   core_din    out  to core data_i
//   core_dout0  in   core share 0
//   core_dout1  in   core share 1
//   core_valid  in   core valid_o
//   core_done   in   core done
//   out_we      out  output buffer write enable
//   out_addr    out  output buffer write address (AW bits)
//   out_wdata   out  unmasked word, core_dout0 ^ core_dout1
//   busy        out  high from accepted start until done pulse, inclusive
//   done        out  one-cycle completion pulse
//   err         out  sticky protocol error flag
//   dbg_state   out  current sequencer state encoding, for observation only
//
// Handshake: every signal is sampled on the rising clock edge. There is no
// backpressure: the core presents a beat by holding core_valid high for one
// cycle, and the sequencer writes it to the output buffer the following cycle.
interface kyber_enc_host_seq_if #(
    parameter int AW = 8
);
    logic          start;
    logic          in_re;
    logic [AW-1:0] in_addr;
    logic [31:0]   in_rdata;
    logic          core_en;
    logic          core_wen;
    logic [31:0]   core_din;
    logic [31:0]   core_dout0;
    logic [31:0]   core_dout1;
    logic          core_valid;
    logic          core_done;
    logic          out_we;
    logic [AW-1:0] out_addr;
    logic [31:0]   out_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    dbg_state;

    modport master (
        input  start, in_rdata, core_dout0, core_dout1, core_valid, core_done,
        output in_re, in_addr, core_en, core_wen, core_din,
               out_we, out_addr, out_wdata, busy, done, err, dbg_state
    );

    modport slave (
        output start, in_rdata, core_dout0, core_dout1, core_valid, core_done,
        input  in_re, in_addr, core_en, core_wen, core_din,
               out_we, out_addr, out_wdata, busy, done, err, dbg_state
    );
endinterface

// File: rtl/kyber_enc_host_seq.sv
// Host-side sequencer for the Kyber PKE encryption core. It pulses core_en,
// streams N_IN words from a synchronous-read input buffer into the core's load
// port, then collects N_OUT masked output beats, unmasks each one
// (dout0 ^ dout1) and writes it to an output buffer at consecutive addresses.
//
// Ports:
//   clk  rising-edge system clock
//   rst  synchronous active-high reset
//   bus  kyber_enc_host_seq_if.master (buffers, core and status signals)
//
// Every output is a register; the FSM computes the next value of each output
// combinationally and a single clocked process loads them.
module kyber_enc_host_seq #(
    parameter int N_IN  = 224,
    parameter int N_OUT = 192,
    parameter int AW    = 8
) (
    input logic                  clk,
    input logic                  rst,
    kyber_enc_host_seq_if.master bus
);
    localparam int KW = $clog2(N_IN) + 1;
    localparam int MW = $clog2(N_OUT) + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        GAP     = 3'd2,
        LOAD    = 3'd3,
        COLLECT = 3'd4,
        FIN     = 3'd5
    } state_t;

    typedef struct packed {
        logic          in_re;
        logic [AW-1:0] in_addr;
        logic          core_en;
        logic          core_wen;
        logic [31:0]   core_din;
        logic          out_we;
        logic [AW-1:0] out_addr;
        logic [31:0]   out_wdata;
        logic          busy;
        logic          done;
        logic          err;
    } outs_t;

    state_t        state, state_n;
    logic [KW-1:0] k, k_n;          // index of the word currently on core_din
    logic [MW-1:0] m, m_n;          // number of beats captured so far
    logic          ran, ran_n;      // a run has been started since reset
    outs_t         o, o_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            m     <= '0;
            ran   <= 1'b0;
            o     <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
            m     <= m_n;
            ran   <= ran_n;
            o     <= o_n;
        end
    end

    always_comb begin
        state_n = state;
        k_n     = k;
        m_n     = m;
        ran_n   = ran;
        // Strobes and data default low; busy and err are level flags that hold.
        o_n      = '0;
        o_n.busy = o.busy;
        o_n.err  = o.err;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n     = START;
                    o_n.core_en = 1'b1;
                    o_n.in_re   = 1'b1;
                    o_n.in_addr = '0;
                    o_n.busy    = 1'b1;
                    o_n.err     = 1'b0;
                    k_n         = '0;
                    m_n         = '0;
                    ran_n       = 1'b1;
                end else if (bus.core_valid && ran) begin
                    // Core produced output while nobody is collecting.
                    o_n.err = 1'b1;
                end
            end

            START: begin
                state_n     = GAP;
                o_n.in_re   = 1'b1;
                o_n.in_addr = AW'(1);
                if (bus.core_valid) o_n.err = 1'b1;
            end

            GAP: begin
                // Read of word 0 issued in START lands now; the read pipeline
                // runs two addresses ahead of the word being presented.
                state_n      = LOAD;
                o_n.core_wen = 1'b1;
                o_n.core_din = bus.in_rdata;
                k_n          = '0;
                if (N_IN > 2) begin
                    o_n.in_re   = 1'b1;
                    o_n.in_addr = AW'(2);
                end
                if (bus.core_valid) o_n.err = 1'b1;
            end

            LOAD: begin
                if (bus.core_valid) o_n.err = 1'b1;
                if (k == KW'(N_IN - 1)) begin
                    state_n = COLLECT;
                end else begin
                    o_n.core_wen = 1'b1;
                    o_n.core_din = bus.in_rdata;
                    k_n          = k + 1'b1;
                    if (32'(k) + 32'd3 < 32'(N_IN)) begin
                        o_n.in_re   = 1'b1;
                        o_n.in_addr = AW'(32'(k) + 32'd3);
                    end
                end
            end

            COLLECT: begin
                if (bus.core_valid) begin
                    o_n.out_we    = 1'b1;
                    o_n.out_addr  = AW'(m);
                    o_n.out_wdata = bus.core_dout0 ^ bus.core_dout1;
                    m_n           = m + 1'b1;
                end
                if (bus.core_valid && m == MW'(N_OUT - 1)) begin
                    state_n  = FIN;
                    o_n.done = 1'b1;
                end else if (bus.core_done) begin
                    // Core finished before delivering every beat: abort.
                    state_n  = FIN;
                    o_n.done = 1'b1;
                    o_n.err  = 1'b1;
                end
            end

            FIN: begin
                state_n  = IDLE;
                o_n.busy = 1'b0;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.in_re     = o.in_re;
    assign bus.in_addr   = o.in_addr;
    assign bus.core_en   = o.core_en;
    assign bus.core_wen  = o.core_wen;
    assign bus.core_din  = o.core_din;
    assign bus.out_we    = o.out_we;
    assign bus.out_addr  = o.out_addr;
    assign bus.out_wdata = o.out_wdata;
    assign bus.busy      = o.busy;
    assign bus.done      = o.done;
    assign bus.err       = o.err;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_kyber_enc_host_seq.sv
// Directed testbench for kyber_enc_host_seq: input buffer model, a simple
// core model that returns masked beats, and per-scenario checking tasks.
module tb_kyber_enc_host_seq;
    localparam int N_IN  = 224;
    localparam int N_OUT = 192;
    localparam int AW    = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kyber_enc_host_seq_if #(.AW(AW)) bus ();

    kyber_enc_host_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read input buffer, mem[k] = k * 0x01010101.
    logic [31:0] mem [256];
    always @(posedge clk) if (bus.in_re) bus.in_rdata <= mem[bus.in_addr];

    // ---------------- run records ----------------
    int            en_cnt, en_rel, wen_cnt, re_cnt, wr_cnt, done_cnt, done_rel;
    logic [31:0]   wen_data [256];
    int            wen_rel  [256];
    logic [AW-1:0] re_addr  [256];
    int            re_rel   [256];
    logic [AW-1:0] wr_addr  [256];
    logic [31:0]   wr_data  [256];
    int            wr_rel   [256];
    int            beat_rel [256];
    logic          busy_r0, busy_r1, busy_after, err_r0, err_r1, err_end, timed_out;
    logic [89:0]   rst_snap;

    // ---------------- driver ----------------
    // Runs one encryption starting at relative cycle 0 (start high). The core
    // model emits beats from cycle 230 every 'period' cycles, stops after
    // 'done_after' beats and then pulses core_done if that is fewer than N_OUT.
    task automatic do_run(input int period, input int done_after, input int stray_k,
                          input int hold_lo, input int hold_len, input int rst_k);
        int t0, rel, next_beat, sent;
        bit fin;
        en_cnt = 0; en_rel = -1; wen_cnt = 0; re_cnt = 0; wr_cnt = 0;
        done_cnt = 0; done_rel = -1; timed_out = 1'b1;
        busy_after = 1'bx; err_end = 1'bx; rst_snap = 'x;
        sent = 0; next_beat = 230; fin = 1'b0;
        @(negedge clk);
        t0 = cyc;
        busy_r0 = bus.busy;
        err_r0  = bus.err;
        bus.start = 1'b1;
        for (int i = 0; i < 3000 && !fin; i++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (rel == 1) begin busy_r1 = bus.busy; err_r1 = bus.err; end
            if (bus.core_en) begin en_cnt++; en_rel = rel; end
            if (bus.core_wen && wen_cnt < 256) begin
                wen_data[wen_cnt] = bus.core_din; wen_rel[wen_cnt] = rel; wen_cnt++;
            end
            if (bus.in_re && re_cnt < 256) begin
                re_addr[re_cnt] = bus.in_addr; re_rel[re_cnt] = rel; re_cnt++;
            end
            if (bus.out_we && wr_cnt < 256) begin
                wr_addr[wr_cnt] = bus.out_addr; wr_data[wr_cnt] = bus.out_wdata;
                wr_rel[wr_cnt] = rel; wr_cnt++;
            end
            if (bus.done) begin done_cnt++; if (done_rel < 0) done_rel = rel; end
            if (done_rel >= 0 && rel == done_rel + 1) begin
                busy_after = bus.busy; err_end = bus.err; timed_out = 1'b0; fin = 1'b1;
            end
            if (rst_k >= 0 && rel == rst_k + 4) begin
                rst_snap = {bus.in_re, bus.in_addr, bus.core_en, bus.core_wen, bus.core_din,
                            bus.out_we, bus.out_addr, bus.out_wdata, bus.busy, bus.done,
                            bus.err, bus.dbg_state};
                rst = 1'b0;
            end
            if (rst_k >= 0 && rel == rst_k + 24) begin timed_out = 1'b0; fin = 1'b1; end

            // inputs for this cycle
            bus.start      = (rel >= hold_lo && rel < hold_lo + hold_len);
            bus.core_valid = 1'b0;
            bus.core_done  = 1'b0;
            bus.core_dout0 = '0;
            bus.core_dout1 = '0;
            if (rst_k >= 0 && rel == rst_k + 3) rst = 1'b1;
            if (stray_k >= 0 && rel == stray_k + 3) begin
                bus.core_valid = 1'b1;
                bus.core_dout0 = 32'hDEAD_BEEF;
            end else if (!fin && rel == next_beat && sent < N_OUT && sent < done_after) begin
                bus.core_valid = 1'b1;
                bus.core_dout0 = 32'hA5A5_A5A5;
                bus.core_dout1 = 32'hA5A5_A5A5 ^ (32'(sent) + 32'h100);
                beat_rel[sent] = rel;
                sent++;
                next_beat = rel + period;
            end else if (done_after < N_OUT && sent == done_after && sent > 0 &&
                         rel == beat_rel[sent-1] + 1) begin
                bus.core_done = 1'b1;
            end
        end
        bus.start = 1'b0; bus.core_valid = 1'b0; bus.core_done = 1'b0;
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_snap = {bus.in_re, bus.in_addr, bus.core_en, bus.core_wen, bus.core_din,
                    bus.out_we, bus.out_addr, bus.out_wdata, bus.busy, bus.done,
                    bus.err, bus.dbg_state};
        checks++;
        if (rst_snap !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", rst_snap);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.core_en !== 1'b0) begin
            errors++; $display("FAIL reset_idle: got busy=%b en=%b expected 0/0", bus.busy, bus.core_en);
        end
    endtask

    task automatic test_nominal();
        do_run(1, N_OUT, -1, -1, 0, -1);
        checks++;
        if (timed_out !== 1'b0) begin errors++; $display("FAIL nominal_timeout: got %b expected 0", timed_out); end
        checks++;
        if (en_cnt !== 1 || en_rel !== 1) begin
            errors++; $display("FAIL nominal_en: got %0d pulses at %0d expected 1 at 1", en_cnt, en_rel);
        end
        checks++;
        if (busy_r0 !== 1'b0 || busy_r1 !== 1'b1) begin
            errors++; $display("FAIL nominal_busy_rise: got %b%b expected 01", busy_r0, busy_r1);
        end
        checks++;
        if (wen_cnt !== N_IN) begin errors++; $display("FAIL nominal_wen_cnt: got %0d expected %0d", wen_cnt, N_IN); end
        for (int k = 0; k < N_IN; k++) begin
            checks++;
            if (wen_data[k] !== 32'(k) * 32'h0101_0101 || wen_rel[k] !== k + 3) begin
                errors++;
                $display("FAIL nominal_wen[%0d]: got %h@%0d expected %h@%0d",
                         k, wen_data[k], wen_rel[k], 32'(k) * 32'h0101_0101, k + 3);
            end
        end
        checks++;
        if (re_cnt !== N_IN) begin errors++; $display("FAIL nominal_re_cnt: got %0d expected %0d", re_cnt, N_IN); end
        for (int j = 0; j < N_IN; j++) begin
            checks++;
            if (re_addr[j] !== AW'(j) || re_rel[j] !== j + 1) begin
                errors++;
                $display("FAIL nominal_in_addr[%0d]: got %0d@%0d expected %0d@%0d", j, re_addr[j], re_rel[j], j, j + 1);
            end
        end
        checks++;
        if (wr_cnt !== N_OUT) begin errors++; $display("FAIL nominal_wr_cnt: got %0d expected %0d", wr_cnt, N_OUT); end
        for (int m = 0; m < N_OUT; m++) begin
            checks++;
            if (wr_addr[m] !== AW'(m) || wr_data[m] !== 32'(m) + 32'h100 || wr_rel[m] !== beat_rel[m] + 1) begin
                errors++;
                $display("FAIL nominal_wr[%0d]: got %0d:%h@%0d expected %0d:%h@%0d", m, wr_addr[m], wr_data[m],
                         wr_rel[m], m, 32'(m) + 32'h100, beat_rel[m] + 1);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_rel !== beat_rel[N_OUT-1] + 1) begin
            errors++;
            $display("FAIL nominal_done: got %0d at %0d expected 1 at %0d", done_cnt, done_rel, beat_rel[N_OUT-1] + 1);
        end
        checks++;
        if (busy_after !== 1'b0 || err_end !== 1'b0) begin
            errors++; $display("FAIL nominal_end: got busy=%b err=%b expected 0/0", busy_after, err_end);
        end
    endtask

    task automatic test_valid_gaps();
        do_run(3, N_OUT, -1, -1, 0, -1);
        checks++;
        if (timed_out !== 1'b0 || wr_cnt !== N_OUT) begin
            errors++; $display("FAIL gaps_wr_cnt: got %0d (timeout=%b) expected %0d", wr_cnt, timed_out, N_OUT);
        end
        for (int m = 0; m < N_OUT; m++) begin
            checks++;
            if (wr_addr[m] !== AW'(m) || wr_data[m] !== 32'(m) + 32'h100 || wr_rel[m] !== beat_rel[m] + 1) begin
                errors++;
                $display("FAIL gaps_wr[%0d]: got %0d:%h@%0d expected %0d:%h@%0d", m, wr_addr[m], wr_data[m],
                         wr_rel[m], m, 32'(m) + 32'h100, beat_rel[m] + 1);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_rel !== beat_rel[N_OUT-1] + 1 || err_end !== 1'b0) begin
            errors++;
            $display("FAIL gaps_done: got %0d at %0d err=%b expected 1 at %0d err=0",
                     done_cnt, done_rel, err_end, beat_rel[N_OUT-1] + 1);
        end
    endtask

    task automatic test_start_hold();
        do_run(1, N_OUT, -1, 10, 50, -1);
        checks++;
        if (timed_out !== 1'b0 || en_cnt !== 1 || done_cnt !== 1) begin
            errors++; $display("FAIL hold_pulses: got en=%0d done=%0d timeout=%b expected 1/1/0", en_cnt, done_cnt, timed_out);
        end
        checks++;
        if (wen_cnt !== N_IN || wr_cnt !== N_OUT) begin
            errors++; $display("FAIL hold_counts: got wen=%0d wr=%0d expected %0d/%0d", wen_cnt, wr_cnt, N_IN, N_OUT);
        end
        for (int k = 0; k < N_IN; k++) begin
            checks++;
            if (wen_data[k] !== 32'(k) * 32'h0101_0101) begin
                errors++; $display("FAIL hold_wen[%0d]: got %h expected %h", k, wen_data[k], 32'(k) * 32'h0101_0101);
            end
        end
        for (int m = 0; m < N_OUT; m++) begin
            checks++;
            if (wr_addr[m] !== AW'(m) || wr_data[m] !== 32'(m) + 32'h100) begin
                errors++; $display("FAIL hold_wr[%0d]: got %0d:%h expected %0d:%h", m, wr_addr[m], wr_data[m], m, 32'(m) + 32'h100);
            end
        end
        checks++;
        if (err_end !== 1'b0) begin errors++; $display("FAIL hold_err: got %b expected 0", err_end); end
    endtask

    // core_done in IDLE is harmless; core_valid in IDLE after a run is an error.
    task automatic test_idle_stray();
        @(negedge clk);
        bus.core_done = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL idle_done_err: got %b expected 0", bus.err); end
        bus.core_done  = 1'b0;
        bus.core_valid = 1'b1;
        bus.core_dout0 = 32'h1234_5678;
        @(negedge clk);
        bus.core_valid = 1'b0;
        checks++;
        if (bus.err !== 1'b1 || bus.out_we !== 1'b0) begin
            errors++; $display("FAIL idle_valid: got err=%b we=%b expected 1/0", bus.err, bus.out_we);
        end
    endtask

    task automatic test_early_done();
        do_run(1, 100, -1, -1, 0, -1);
        checks++;
        if (timed_out !== 1'b0 || wr_cnt !== 100) begin
            errors++; $display("FAIL early_wr_cnt: got %0d (timeout=%b) expected 100", wr_cnt, timed_out);
        end
        for (int m = 0; m < 100; m++) begin
            checks++;
            if (wr_addr[m] !== AW'(m) || wr_data[m] !== 32'(m) + 32'h100) begin
                errors++; $display("FAIL early_wr[%0d]: got %0d:%h expected %0d:%h", m, wr_addr[m], wr_data[m], m, 32'(m) + 32'h100);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_rel !== beat_rel[99] + 2) begin
            errors++; $display("FAIL early_done: got %0d at %0d expected 1 at %0d", done_cnt, done_rel, beat_rel[99] + 2);
        end
        checks++;
        if (err_end !== 1'b1 || busy_after !== 1'b0) begin
            errors++; $display("FAIL early_flags: got err=%b busy=%b expected 1/0", err_end, busy_after);
        end
        // Next run: err still set before the start is accepted, cleared after.
        do_run(1, N_OUT, -1, -1, 0, -1);
        checks++;
        if (err_r0 !== 1'b1 || err_r1 !== 1'b0) begin
            errors++; $display("FAIL early_err_clear: got %b%b expected 10", err_r0, err_r1);
        end
        checks++;
        if (timed_out !== 1'b0 || wr_cnt !== N_OUT || err_end !== 1'b0) begin
            errors++; $display("FAIL early_rerun: got wr=%0d err=%b expected %0d/0", wr_cnt, err_end, N_OUT);
        end
    endtask

    task automatic test_rst_mid();
        do_run(1, N_OUT, -1, -1, 0, 50);
        checks++;
        if (rst_snap !== '0) begin errors++; $display("FAIL rst_outputs: got %h expected 0", rst_snap); end
        checks++;
        if (wen_cnt !== 51 || en_cnt !== 1 || wr_cnt !== 0) begin
            errors++; $display("FAIL rst_activity: got wen=%0d en=%0d wr=%0d expected 51/1/0", wen_cnt, en_cnt, wr_cnt);
        end
        checks++;
        if (wen_data[50] !== 32'd50 * 32'h0101_0101) begin
            errors++; $display("FAIL rst_last_word: got %h expected %h", wen_data[50], 32'd50 * 32'h0101_0101);
        end
        do_run(1, N_OUT, -1, -1, 0, -1);
        checks++;
        if (timed_out !== 1'b0 || en_rel !== 1 || wen_cnt !== N_IN || wr_cnt !== N_OUT || done_cnt !== 1) begin
            errors++;
            $display("FAIL rst_rerun_counts: got en@%0d wen=%0d wr=%0d done=%0d expected 1/%0d/%0d/1",
                     en_rel, wen_cnt, wr_cnt, done_cnt, N_IN, N_OUT);
        end
        for (int k = 0; k < N_IN; k++) begin
            checks++;
            if (wen_data[k] !== 32'(k) * 32'h0101_0101 || wen_rel[k] !== k + 3) begin
                errors++; $display("FAIL rst_rerun_wen[%0d]: got %h@%0d expected %h@%0d", k, wen_data[k], wen_rel[k],
                                   32'(k) * 32'h0101_0101, k + 3);
            end
        end
        for (int m = 0; m < N_OUT; m++) begin
            checks++;
            if (wr_addr[m] !== AW'(m) || wr_data[m] !== 32'(m) + 32'h100) begin
                errors++; $display("FAIL rst_rerun_wr[%0d]: got %0d:%h expected %0d:%h", m, wr_addr[m], wr_data[m], m, 32'(m) + 32'h100);
            end
        end
        checks++;
        if (err_end !== 1'b0) begin errors++; $display("FAIL rst_rerun_err: got %b expected 0", err_end); end
    endtask

    task automatic test_stray_load();
        do_run(1, N_OUT, 20, -1, 0, -1);
        checks++;
        if (timed_out !== 1'b0 || err_end !== 1'b1) begin
            errors++; $display("FAIL stray_err: got %b (timeout=%b) expected 1", err_end, timed_out);
        end
        checks++;
        if (wr_cnt !== N_OUT || wen_cnt !== N_IN) begin
            errors++; $display("FAIL stray_counts: got wr=%0d wen=%0d expected %0d/%0d", wr_cnt, wen_cnt, N_OUT, N_IN);
        end
        for (int m = 0; m < N_OUT; m++) begin
            checks++;
            if (wr_addr[m] !== AW'(m) || wr_data[m] !== 32'(m) + 32'h100) begin
                errors++; $display("FAIL stray_wr[%0d]: got %0d:%h expected %0d:%h", m, wr_addr[m], wr_data[m], m, 32'(m) + 32'h100);
            end
        end
        checks++;
        if (done_cnt !== 1 || busy_after !== 1'b0) begin
            errors++; $display("FAIL stray_done: got %0d busy=%b expected 1/0", done_cnt, busy_after);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.core_valid = 1'b0;
        bus.core_done  = 1'b0;
        bus.core_dout0 = '0;
        bus.core_dout1 = '0;
        for (int k = 0; k < 256; k++) mem[k] = 32'(k) * 32'h0101_0101;

        test_reset();
        test_nominal();
        test_valid_gaps();
        test_start_hold();
        test_idle_stray();
        test_early_done();
        test_rst_mid();
        test_stray_load();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
